// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID->EX pipeline register with bubble insertion, flush and delay-slot feedback.
// Ports:
//   clk_i, rst_n_i                 clock, asynchronous active-low reset
//   id_stall_i, ex_stall_i         stage hold requests; flush_i clears the EX stage
//   id_*_i                         decoded control word and forwarded operands from ID
//   ex_*_o                         registered copies presented to EX (all zero = NOP)
//   id_is_dslot_o                  delay-slot flag fed back to ID
//   bubble_cnt_o, flush_cnt_o      saturating perf counters (ID_EX_PERF_EN), otherwise 0
// Optional feature macro: ID_EX_PERF_EN
module id_ex_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int ALUOP_W    = 8,
    parameter int ALUSEL_W   = 3,
    parameter int PERF_CNT_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  id_stall_i,
    input  logic                  ex_stall_i,
    input  logic                  flush_i,
    input  logic [ALUOP_W-1:0]    id_aluop_i,
    input  logic [ALUSEL_W-1:0]   id_alusel_i,
    input  logic [DATA_W-1:0]     id_reg1_i,
    input  logic [DATA_W-1:0]     id_reg2_i,
    input  logic                  id_we_i,
    input  logic [4:0]            id_waddr_i,
    input  logic [DATA_W-1:0]     id_inst_i,
    input  logic [DATA_W-1:0]     id_pc_i,
    input  logic [DATA_W-1:0]     id_link_addr_i,
    input  logic                  id_in_dslot_i,
    input  logic                  id_next_dslot_i,
    output logic [ALUOP_W-1:0]    ex_aluop_o,
    output logic [ALUSEL_W-1:0]   ex_alusel_o,
    output logic [DATA_W-1:0]     ex_reg1_o,
    output logic [DATA_W-1:0]     ex_reg2_o,
    output logic                  ex_we_o,
    output logic [4:0]            ex_waddr_o,
    output logic [DATA_W-1:0]     ex_inst_o,
    output logic [DATA_W-1:0]     ex_pc_o,
    output logic [DATA_W-1:0]     ex_link_addr_o,
    output logic                  ex_in_dslot_o,
    output logic                  id_is_dslot_o,
    output logic [PERF_CNT_W-1:0] bubble_cnt_o,
    output logic [PERF_CNT_W-1:0] flush_cnt_o
);
    localparam int WORD_W = ALUOP_W + ALUSEL_W + 5 * DATA_W + 7;
    logic [WORD_W-1:0] w_id_word;
    logic [WORD_W-1:0] r_ex_word;
    logic              r_is_dslot;
    logic              w_bubble;
    assign w_id_word = {id_aluop_i, id_alusel_i, id_reg1_i, id_reg2_i, id_we_i, id_waddr_i,
                        id_inst_i, id_pc_i, id_link_addr_i, id_in_dslot_i};
    assign {ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_we_o, ex_waddr_o,
            ex_inst_o, ex_pc_o, ex_link_addr_o, ex_in_dslot_o} = r_ex_word;
    assign id_is_dslot_o = r_is_dslot;
    assign w_bubble = id_stall_i & ~ex_stall_i;
    // A bubble keeps the delay-slot flag: the branch is still sitting in ID.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ex_word  <= '0;
            r_is_dslot <= 1'b0;
        end else if (flush_i) begin
            r_ex_word  <= '0;
            r_is_dslot <= 1'b0;
        end else if (w_bubble) begin
            r_ex_word  <= '0;
        end else if (!ex_stall_i) begin
            r_ex_word  <= w_id_word;
            r_is_dslot <= id_next_dslot_i;
        end
    end
`ifdef ID_EX_PERF_EN
    logic [PERF_CNT_W-1:0] r_bubble_cnt;
    logic [PERF_CNT_W-1:0] r_flush_cnt;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (!flush_i && w_bubble && !(&r_bubble_cnt)) r_bubble_cnt <= r_bubble_cnt + 1'b1;
            if (flush_i && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end
    assign bubble_cnt_o = r_bubble_cnt;
    assign flush_cnt_o  = r_flush_cnt;
`else
    assign bubble_cnt_o = '0;
    assign flush_cnt_o  = '0;
`endif
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: self-checking bench for id_ex_pipe_reg (vector table, corner sequences, random vs model).
module tb_id_ex_pipe_reg;
    localparam int PW = 2;
`ifdef ID_EX_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam int SAT = (1 << PW) - 1;
    localparam int AW = 8 + 3 + 5 * 32 + 7 + 1 + 2 * PW;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_stall = 1'b0, ex_stall = 1'b0, flush = 1'b0;
    logic [7:0]  id_aluop = '0;
    logic [2:0]  id_alusel = '0;
    logic [31:0] id_reg1 = '0, id_reg2 = '0, id_inst = '0, id_pc = '0, id_link = '0;
    logic        id_we = 1'b0;
    logic [4:0]  id_waddr = '0;
    logic        id_in_dslot = 1'b0, id_next_dslot = 1'b0;
    logic [7:0]  ex_aluop;
    logic [2:0]  ex_alusel;
    logic [31:0] ex_reg1, ex_reg2, ex_inst, ex_pc, ex_link;
    logic        ex_we;
    logic [4:0]  ex_waddr;
    logic        ex_in_dslot, id_is_dslot;
    logic [PW-1:0] bubble_cnt, flush_cnt;
    logic [AW-1:0] act;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.DATA_W(32), .ALUOP_W(8), .ALUSEL_W(3), .PERF_CNT_W(PW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .id_stall_i(id_stall), .ex_stall_i(ex_stall), .flush_i(flush),
        .id_aluop_i(id_aluop), .id_alusel_i(id_alusel), .id_reg1_i(id_reg1), .id_reg2_i(id_reg2),
        .id_we_i(id_we), .id_waddr_i(id_waddr), .id_inst_i(id_inst), .id_pc_i(id_pc),
        .id_link_addr_i(id_link), .id_in_dslot_i(id_in_dslot), .id_next_dslot_i(id_next_dslot),
        .ex_aluop_o(ex_aluop), .ex_alusel_o(ex_alusel), .ex_reg1_o(ex_reg1), .ex_reg2_o(ex_reg2),
        .ex_we_o(ex_we), .ex_waddr_o(ex_waddr), .ex_inst_o(ex_inst), .ex_pc_o(ex_pc),
        .ex_link_addr_o(ex_link), .ex_in_dslot_o(ex_in_dslot), .id_is_dslot_o(id_is_dslot),
        .bubble_cnt_o(bubble_cnt), .flush_cnt_o(flush_cnt)
    );

    assign act = {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_we, ex_waddr, ex_inst, ex_pc, ex_link,
                  ex_in_dslot, id_is_dslot, bubble_cnt, flush_cnt};

    typedef struct {
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] reg1, reg2, inst, pc, link;
        logic        we;
        logic [4:0]  waddr;
        logic        in_dslot, is_dslot;
        int          bcnt, fcnt;
    } model_t;

    model_t m;

    function automatic model_t nop_of(input model_t x);
        model_t y = x;
        y.aluop = '0; y.alusel = '0; y.reg1 = '0; y.reg2 = '0; y.inst = '0;
        y.pc = '0; y.link = '0; y.we = 1'b0; y.waddr = '0; y.in_dslot = 1'b0;
        return y;
    endfunction

    function automatic model_t reset_model();
        model_t y;
        y = nop_of(y);
        y.is_dslot = 1'b0; y.bcnt = 0; y.fcnt = 0;
        return y;
    endfunction

    function automatic logic [AW-1:0] exp_word(input model_t x);
        logic [PW-1:0] b = x.bcnt[PW-1:0];
        logic [PW-1:0] f = x.fcnt[PW-1:0];
        return {x.aluop, x.alusel, x.reg1, x.reg2, x.we, x.waddr, x.inst, x.pc, x.link,
                x.in_dslot, x.is_dslot, b, f};
    endfunction

    task automatic chk(input string name, input logic [255:0] a, input logic [255:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, a, e);
        end
    endtask

    // Applies the current inputs for one edge, advancing the reference model by the stage rules.
    task automatic tick();
        model_t n = m;
        if (flush) begin
            n = nop_of(n);
            n.is_dslot = 1'b0;
            if (PERF && n.fcnt < SAT) n.fcnt++;
        end else if (id_stall && !ex_stall) begin
            n = nop_of(n);
            if (PERF && n.bcnt < SAT) n.bcnt++;
        end else if (!ex_stall) begin
            n.aluop = id_aluop; n.alusel = id_alusel; n.reg1 = id_reg1; n.reg2 = id_reg2;
            n.inst = id_inst; n.pc = id_pc; n.link = id_link; n.we = id_we; n.waddr = id_waddr;
            n.in_dslot = id_in_dslot; n.is_dslot = id_next_dslot;
        end
        @(posedge clk);
        #1;
        m = n;
        chk("state", 256'(act), 256'(exp_word(m)));
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        m = reset_model();
        chk("async_reset", 256'(act), 256'd0);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic ctl(input logic is, input logic es, input logic fl);
        id_stall = is; ex_stall = es; flush = fl;
    endtask

    typedef struct {
        logic        is, es, fl, we, nd;
        logic [7:0]  aluop;
        logic [31:0] reg1;
        logic [4:0]  waddr;
        logic [7:0]  e_aluop;
        logic [31:0] e_reg1;
        logic [4:0]  e_waddr;
        logic        e_we, e_isd;
    } vec_t;

    vec_t vt[9];

    initial begin
        vt[0] = '{0,0,0,1,0, 8'h21, 32'h1234_5678, 5'd9,  8'h21, 32'h1234_5678, 5'd9,  1,0};
        vt[1] = '{0,0,0,1,1, 8'h05, 32'h0000_AAAA, 5'd3,  8'h05, 32'h0000_AAAA, 5'd3,  1,1};
        vt[2] = '{1,1,0,0,0, 8'h77, 32'h0000_BBBB, 5'd4,  8'h05, 32'h0000_AAAA, 5'd3,  1,1};
        vt[3] = '{1,0,0,1,0, 8'h66, 32'h0000_CCCC, 5'd5,  8'h00, 32'h0,         5'd0,  0,1};
        vt[4] = '{0,1,0,1,0, 8'h11, 32'h0000_1111, 5'd6,  8'h00, 32'h0,         5'd0,  0,1};
        vt[5] = '{0,0,0,1,0, 8'h33, 32'h0000_DDDD, 5'd7,  8'h33, 32'h0000_DDDD, 5'd7,  1,0};
        vt[6] = '{1,1,1,1,1, 8'h44, 32'h0000_4444, 5'd8,  8'h00, 32'h0,         5'd0,  0,0};
        vt[7] = '{0,0,0,0,1, 8'h22, 32'h0000_EEEE, 5'd31, 8'h22, 32'h0000_EEEE, 5'd31, 0,1};
        vt[8] = '{0,0,1,1,0, 8'h99, 32'h0000_9999, 5'd2,  8'h00, 32'h0,         5'd0,  0,0};

        m = reset_model();
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        id_we = 1'b1; id_aluop = 8'h5A; id_reg1 = 32'hFFFF_0000;
        tick();
        do_reset();

        // Vector table from reset state.
        foreach (vt[i]) begin
            ctl(vt[i].is, vt[i].es, vt[i].fl);
            id_we = vt[i].we; id_next_dslot = vt[i].nd; id_aluop = vt[i].aluop;
            id_reg1 = vt[i].reg1; id_waddr = vt[i].waddr;
            tick();
            chk($sformatf("vec%0d_aluop", i), 256'(ex_aluop), 256'(vt[i].e_aluop));
            chk($sformatf("vec%0d_reg1", i), 256'(ex_reg1), 256'(vt[i].e_reg1));
            chk($sformatf("vec%0d_waddr", i), 256'(ex_waddr), 256'(vt[i].e_waddr));
            chk($sformatf("vec%0d_we", i), 256'(ex_we), 256'(vt[i].e_we));
            chk($sformatf("vec%0d_isdslot", i), 256'(id_is_dslot), 256'(vt[i].e_isd));
        end

        // Bubble with a branch held in ID: delay-slot flag must not advance until release.
        ctl(0, 0, 0); id_next_dslot = 1'b0; id_we = 1'b1; id_aluop = 8'h10; id_pc = 32'h100;
        tick();
        ctl(1, 0, 0); id_next_dslot = 1'b1; id_aluop = 8'h04; id_pc = 32'h104;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("bubble_we", 256'(ex_we), 256'd0);
            chk("bubble_aluop", 256'(ex_aluop), 256'd0);
            chk("bubble_pc", 256'(ex_pc), 256'd0);
            chk("bubble_isdslot", 256'(id_is_dslot), 256'd0);
        end
        ctl(0, 0, 0);
        tick();
        chk("release_isdslot", 256'(id_is_dslot), 256'd1);
        chk("release_pc", 256'(ex_pc), 256'h104);

        // EX hold keeps the loaded word across changing ID inputs.
        id_next_dslot = 1'b0; id_aluop = 8'h21;
        tick();
        ctl(1, 1, 0);
        for (int k = 0; k < 3; k++) begin
            id_aluop = 8'h30 + 8'(k); id_reg2 = $urandom; id_inst = $urandom;
            tick();
            chk("exhold_aluop", 256'(ex_aluop), 256'h21);
        end

        // Flush wins over both stalls and clears the delay-slot flag.
        ctl(0, 0, 0); id_next_dslot = 1'b1; id_link = 32'hDEAD_BEEF;
        tick();
        chk("pre_flush_isdslot", 256'(id_is_dslot), 256'd1);
        ctl(1, 1, 1);
        tick();
        chk("flush_word", 256'(act[AW-1:2*PW+1]), 256'd0);
        chk("flush_isdslot", 256'(id_is_dslot), 256'd0);

        // Perf counters: five bubble edges saturate a 2-bit counter.
        do_reset();
        ctl(1, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("bubble_cnt_%0d", k), 256'(bubble_cnt), 256'(PERF ? (k < SAT ? k : SAT) : 0));
        end
        ctl(0, 0, 1);
        tick();
        chk("flush_cnt_1", 256'(flush_cnt), 256'(PERF ? 1 : 0));

        // Randomized traffic against the reference model.
        for (int k = 0; k < 600; k++) begin
            id_stall = ($urandom_range(0, 2) == 0);
            ex_stall = ($urandom_range(0, 3) == 0);
            if (ex_stall && $urandom_range(0, 7) != 0) id_stall = 1'b1;
            flush = ($urandom_range(0, 15) == 0);
            id_aluop = 8'($urandom); id_alusel = 3'($urandom); id_reg1 = $urandom; id_reg2 = $urandom;
            id_we = 1'($urandom); id_waddr = 5'($urandom); id_inst = $urandom; id_pc = $urandom;
            id_link = $urandom; id_in_dslot = 1'($urandom); id_next_dslot = 1'($urandom);
            tick();
            if (k == 300) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
